// File: rtl/router_wrap_olck_arb_if.sv
// Signal bundle between input ports, the output-lock arbiter and the downstream link.
// No storage of its own; zero latency.
// Backpressure: per-input req_ready from the arbiter, downstream returns credits on credit_in.
interface router_wrap_olck_arb_if #(
    parameter int NUM_IN  = 4,
    parameter int FLIT_W  = 32,
    parameter int CREDITS = 4,
    parameter int IDX_W   = $clog2(NUM_IN),
    parameter int CNT_W   = $clog2(CREDITS + 1)
);
    // input side
    logic [NUM_IN-1:0]        req_valid;
    logic [NUM_IN-1:0]        req_head;
    logic [NUM_IN-1:0]        req_tail;
    logic [NUM_IN*FLIT_W-1:0] req_flit;
    logic [NUM_IN-1:0]        req_ready;

    // downstream side
    logic                     credit_in;
    logic                     out_valid;
    logic [FLIT_W-1:0]        out_flit;
    logic                     out_head;
    logic                     out_tail;

    // lock and credit status
    logic                     olck;
    logic [IDX_W-1:0]         olck_owner;
    logic [CNT_W-1:0]         credit_cnt;
    logic                     credit_err;

    // the side that presents flits and returns credits
    modport master (
        output req_valid, req_head, req_tail, req_flit, credit_in,
        input  req_ready, out_valid, out_flit, out_head, out_tail,
               olck, olck_owner, credit_cnt, credit_err
    );

    // the arbiter itself
    modport slave (
        input  req_valid, req_head, req_tail, req_flit, credit_in,
        output req_ready, out_valid, out_flit, out_head, out_tail,
               olck, olck_owner, credit_cnt, credit_err
    );
endinterface

// File: rtl/router_wrap_olck_arb.sv
// Output-port lock arbiter: round-robin grant on head flits, lock held to the tail, credit tracking.
// Latency: grant one cycle after a head is seen; accepted flit appears on out_* one cycle later.
// Backpressure: req_ready only for the lock owner and only while credit_cnt > 0; no flit taken at grant.
module router_wrap_olck_arb #(
    parameter int NUM_IN  = 4,
    parameter int FLIT_W  = 32,
    parameter int CREDITS = 4,
    parameter int IDX_W   = $clog2(NUM_IN),
    parameter int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    router_wrap_olck_arb_if.slave bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef struct packed {
        logic              head;
        logic              tail;
        logic [FLIT_W-1:0] dat;
    } flit_t;

    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDITS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_IN - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  credit_q, credit_d;
    logic              credit_err_q, credit_err_d;
    logic              out_valid_q;
    flit_t             out_q;

    logic [NUM_IN-1:0] cand;
    logic              hi_vld, lo_vld, grant_vld;
    logic [IDX_W-1:0]  hi_idx, lo_idx, grant_idx;
    logic              owner_vld;
    flit_t             owner_flit;
    logic              credit_avail;
    logic              accept;
    logic [NUM_IN-1:0] ready;

    assign cand         = bus.req_valid & bus.req_head;
    assign credit_avail = (credit_q != '0);
    assign accept       = (state_q == LOCKED) && owner_vld && credit_avail;

    // Round-robin pick: lowest candidate at or above rr_ptr, else lowest candidate overall (wrap).
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (cand[i] && (IDX_W'(i) >= rr_ptr_q)) begin
                hi_vld = 1'b1;
                hi_idx = IDX_W'(i);
            end
            if (cand[i]) begin
                lo_vld = 1'b1;
                lo_idx = IDX_W'(i);
            end
        end
        grant_vld = hi_vld | lo_vld;
        grant_idx = hi_vld ? hi_idx : lo_idx;
    end

    // Select the current owner's request, markers and payload.
    always_comb begin
        owner_vld  = 1'b0;
        owner_flit = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_vld       = bus.req_valid[i];
                owner_flit.head = bus.req_head[i];
                owner_flit.tail = bus.req_tail[i];
                owner_flit.dat  = bus.req_flit[i*FLIT_W +: FLIT_W];
            end
        end
    end

    // Ready goes only to the owner, and only in the cycle its flit is actually taken.
    always_comb begin
        ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            ready[i] = accept && (owner_q == IDX_W'(i));
        end
    end

    // Lock FSM: grant from IDLE needs a credit; release on an accepted tail and advance rr_ptr past the owner.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (grant_vld && credit_avail) begin
                    state_d = LOCKED;
                    owner_d = grant_idx;
                end
            end
            LOCKED: begin
                if (accept && owner_flit.tail) begin
                    state_d  = IDLE;
                    rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Credit counter: return and spend cancel; a return at full is dropped and flagged sticky.
    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        if (bus.credit_in && (credit_q == CREDIT_MAX)) begin
            credit_err_d = 1'b1;
        end
        case ({bus.credit_in, accept})
            2'b10: begin
                if (credit_q != CREDIT_MAX) begin
                    credit_d = credit_q + CNT_W'(1);
                end
            end
            2'b01:   credit_d = credit_q - CNT_W'(1);
            default: credit_d = credit_q;
        endcase
    end

    // Control state registers; reset aborts any lock in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            credit_q     <= CREDIT_MAX;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
        end
    end

    // Forwarding stage: out_valid pulses for each accepted flit; payload holds between flits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                out_q <= owner_flit;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_flit   = out_q.dat;
    assign bus.out_head   = out_q.head;
    assign bus.out_tail   = out_q.tail;
    assign bus.olck       = (state_q == LOCKED);
    assign bus.olck_owner = owner_q;
    assign bus.credit_cnt = credit_q;
    assign bus.credit_err = credit_err_q;

endmodule

// File: tb/tb_router_wrap_olck_arb.sv
// Bench for the output-lock arbiter: directed scenarios followed by random traffic.
// Expected values come from a packet-level reference model of the port plus constant targets.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_router_wrap_olck_arb;

    localparam int N = 4;
    localparam int W = 32;
    localparam int C = 4;

    typedef struct packed {
        logic [W-1:0] dat;
        logic         head;
        logic         tail;
    } tflit_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    router_wrap_olck_arb_if #(.NUM_IN(N), .FLIT_W(W), .CREDITS(C)) bus ();

    router_wrap_olck_arb #(.NUM_IN(N), .FLIT_W(W), .CREDITS(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // stimulus state
    tflit_t       srcq [N][$];
    logic [N-1:0] hold, junk;
    logic         cin;
    logic [N-1:0] cur_v, cur_h, cur_t;
    logic [W-1:0] cur_f [N];

    // reference model state
    bit           m_locked;
    int           m_owner, m_rr, m_cnt;
    bit           m_err;
    bit           exp_ov, exp_oh, exp_ot;
    logic [W-1:0] exp_of;

    // observations of the DUT
    int  cyc = 0;
    int  ov_count = 0;
    int  pushed = 0;
    int  last_tail0_cyc = -100;
    bit  prev_olck = 1'b0;
    int  glog[$];
    int  gcyc[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_rr     = 0;
        m_cnt    = C;
        m_err    = 1'b0;
        exp_ov   = 1'b0;
        exp_oh   = 1'b0;
        exp_ot   = 1'b0;
        exp_of   = '0;
        for (int i = 0; i < N; i++) srcq[i].delete();
    endtask

    task automatic add_pkt(input int i, input int len, input logic [W-1:0] base);
        tflit_t f;
        for (int k = 0; k < len; k++) begin
            f.dat  = base + W'(k);
            f.head = (k == 0);
            f.tail = (k == len - 1);
            srcq[i].push_back(f);
            pushed++;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() != 0 && !hold[i]) begin
                cur_v[i] = 1'b1;
                cur_h[i] = srcq[i][0].head;
                cur_t[i] = srcq[i][0].tail;
                cur_f[i] = srcq[i][0].dat;
            end else if (srcq[i].size() == 0 && junk[i]) begin
                cur_v[i] = 1'b1;
                cur_h[i] = 1'b0;
                cur_t[i] = 1'($urandom_range(0, 1));
                cur_f[i] = $urandom;
            end else begin
                cur_v[i] = 1'b0;
                cur_h[i] = 1'($urandom_range(0, 1));
                cur_t[i] = 1'($urandom_range(0, 1));
                cur_f[i] = $urandom;
            end
            bus.req_valid[i]          = cur_v[i];
            bus.req_head[i]           = cur_h[i];
            bus.req_tail[i]           = cur_t[i];
            bus.req_flit[i*W +: W]    = cur_f[i];
        end
        bus.credit_in = cin;
    endtask

    // One clock cycle: drive, compare against the model on the falling edge, advance the model.
    task automatic step();
        bit           acc;
        logic [N-1:0] exp_rdy;
        int           gnt;
        int           idx;
        drive();
        @(negedge clk);
        acc     = m_locked && cur_v[m_owner] && (m_cnt > 0);
        exp_rdy = '0;
        if (acc) exp_rdy[m_owner] = 1'b1;
        check("req_ready",  bus.req_ready,  exp_rdy);
        check("olck",       bus.olck,       m_locked);
        check("olck_owner", bus.olck_owner, m_owner);
        check("credit_cnt", bus.credit_cnt, m_cnt);
        check("credit_err", bus.credit_err, m_err);
        check("out_valid",  bus.out_valid,  exp_ov);
        check("out_flit",   bus.out_flit,   exp_of);
        check("out_head",   bus.out_head,   exp_oh);
        check("out_tail",   bus.out_tail,   exp_ot);
        if (bus.out_valid === 1'b1) begin
            ov_count++;
            if (bus.out_tail === 1'b1 && bus.out_flit[31:24] == 8'h00) last_tail0_cyc = cyc;
        end
        if (bus.olck === 1'b1 && !prev_olck) begin
            glog.push_back(int'(bus.olck_owner));
            gcyc.push_back(cyc);
        end
        prev_olck = (bus.olck === 1'b1);
        if (!reset) begin
            model_reset();
        end else begin
            gnt = -1;
            if (!m_locked && m_cnt > 0) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (gnt < 0 && cur_v[idx] && cur_h[idx]) gnt = idx;
                end
            end
            exp_ov = acc;
            if (acc) begin
                exp_of = cur_f[m_owner];
                exp_oh = cur_h[m_owner];
                exp_ot = cur_t[m_owner];
                void'(srcq[m_owner].pop_front());
            end
            if (cin && m_cnt == C) m_err = 1'b1;
            if (cin && !acc)      m_cnt = (m_cnt == C) ? C : m_cnt + 1;
            else if (acc && !cin) m_cnt = m_cnt - 1;
            if (gnt >= 0) begin
                m_locked = 1'b1;
                m_owner  = gnt;
            end else if (acc && cur_t[m_owner]) begin
                m_locked = 1'b0;
                m_rr     = (m_owner + 1) % N;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cin   = 1'b0;
        hold  = '0;
        junk  = '0;
        model_reset();
        repeat (2) step();
        reset = 1'b1;
        glog.delete();
        gcyc.delete();
        ov_count = 0;
        pushed   = 0;
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        hold = '0;
        junk = '0;
        while (pending() && n < budget) begin
            cin = (m_cnt < C);
            step();
            n++;
        end
        cin = 1'b0;
        repeat (2) step();
    endtask

    task automatic wait_cnt(input int target, input int budget);
        int n = 0;
        while (int'(bus.credit_cnt) != target && n < budget) begin
            step();
            n++;
        end
        check("wait_credit_cnt", bus.credit_cnt, target);
    endtask

    initial begin
        int exp_order [6] = '{0, 1, 3, 0, 1, 3};
        int g1;
        reset = 1'b1;
        cin   = 1'b0;
        hold  = '0;
        junk  = '0;
        model_reset();
        #2;

        // Reset values, then a valid non-head flit in IDLE must not cause a grant
        do_reset();
        check("rst_credit_cnt", bus.credit_cnt, C);
        junk[0] = 1'b1;
        repeat (2) step();
        junk[0] = 1'b0;
        check("nonhead_no_grant", bus.olck, 1'b0);

        // Single-flit packet on input 2
        add_pkt(2, 1, 32'hA5A5_0001);
        step();
        step();
        check("single_out_valid", bus.out_valid,  1'b1);
        check("single_out_flit",  bus.out_flit,   32'hA5A5_0001);
        check("single_credit",    bus.credit_cnt, 3);
        check("single_idle",      bus.olck,       1'b0);
        glog.delete();
        add_pkt(0, 1, 32'h0000_0001);
        add_pkt(3, 1, 32'h0300_0001);
        step();
        step();
        check("rr_after_single", (glog.size() > 0) ? glog[0] : -1, 3);
        drain(40);

        // Round-robin fairness: inputs 0, 1, 3 with credits returned every cycle
        do_reset();
        for (int p = 0; p < 2; p++) begin
            add_pkt(0, 1, 32'h0000_1000 + W'(p));
            add_pkt(1, 1, 32'h0100_1000 + W'(p));
            add_pkt(3, 1, 32'h0300_1000 + W'(p));
        end
        cin = 1'b1;
        repeat (20) step();
        cin = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("rr_order", (k < glog.size()) ? glog[k] : -1, exp_order[k]);
        end

        // Credit exhaustion: 6-flit packet, 4 credits, then one credit pulse
        do_reset();
        add_pkt(1, 6, 32'h0100_2000);
        repeat (12) step();
        check("exhaust_fwd_count", ov_count, 4);
        check("exhaust_locked",    bus.olck, 1'b1);
        check("exhaust_ready",     bus.req_ready, 4'b0000);
        cin = 1'b1;
        step();
        cin = 1'b0;
        repeat (5) step();
        check("one_credit_one_flit", ov_count, 5);
        drain(40);
        check("exhaust_total", ov_count, 6);

        // Lock hold: input 1's head waits for input 0's tail
        do_reset();
        add_pkt(0, 3, 32'h0000_4000);
        step();
        add_pkt(1, 1, 32'h0100_4000);
        repeat (10) step();
        g1 = -100;
        for (int k = 0; k < glog.size(); k++) if (glog[k] == 1) g1 = gcyc[k];
        check("lock_hold_first", (glog.size() > 0) ? glog[0] : -1, 0);
        check("lock_hold_gap", g1 - last_tail0_cyc, 1);
        drain(40);

        // Credit overflow is sticky; return plus spend at count 2 leaves 2
        do_reset();
        cin = 1'b1;
        step();
        cin = 1'b0;
        step();
        check("ovf_err",   bus.credit_err, 1'b1);
        check("ovf_count", bus.credit_cnt, C);
        add_pkt(0, 4, 32'h0000_5000);
        wait_cnt(2, 20);
        cin = 1'b1;
        step();
        cin = 1'b0;
        check("simul_count", bus.credit_cnt, 2);
        drain(40);
        check("err_sticky", bus.credit_err, 1'b1);

        // Reset asserted mid-packet acts without a clock edge
        do_reset();
        cin = 1'b1;
        step();
        cin = 1'b0;
        add_pkt(3, 6, 32'h0300_6000);
        wait_cnt(1, 20);
        check("pre_rst_locked", bus.olck,       1'b1);
        check("pre_rst_err",    bus.credit_err, 1'b1);
        reset = 1'b0;
        #1;
        check("async_olck",   bus.olck,       1'b0);
        check("async_ovalid", bus.out_valid,  1'b0);
        check("async_credit", bus.credit_cnt, C);
        check("async_err",    bus.credit_err, 1'b0);
        model_reset();
        step();
        reset = 1'b1;

        // Random traffic with valid drops, junk non-head flits and random credit returns
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    add_pkt(i, int'($urandom_range(1, 4)), {8'(i), 8'(c), 16'h0000});
                end
                hold[i] = ($urandom_range(0, 9) == 0);
                junk[i] = ($urandom_range(0, 5) == 0);
            end
            cin = 1'($urandom_range(0, 1));
            step();
        end
        drain(300);
        check("rand_fwd_total", ov_count, pushed);
        check("rand_end_idle",  bus.olck, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/router_wrap_olck_arb.md
# router_wrap_olck_arb

Output-side lock arbiter and credit tracker for one router output port of the router tile. It is the counterpart of the input-lock (ILCK) flip-flops on the receive side. It grants the output to one input port's packet using round-robin on head flits and holds that lock until the tail flit has passed. It forwards flits through one registered stage and spends one downstream credit per forwarded flit.

## Interface
- NUM_IN, 4: number of competing input ports (≥2).
- FLIT_W, 32: flit payload width.
- CREDITS, 4: downstream buffer depth, which is also the credit counter reset value (≥1).
- IDX_W, $clog2(NUM_IN): width of the owner index.
- CNT_W, $clog2(CREDITS+1): width of the credit counter.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous active-low reset; low = reset.
- req_valid  input  NUM_IN  input i presents a flit for this output.
- req_head  input  NUM_IN  input i's flit is a head flit.
- req_tail  input  NUM_IN  input i's flit is a tail flit (head+tail = single-flit packet).
- req_flit  input  NUM_IN*FLIT_W  flit payloads; input i occupies bits [i*FLIT_W +: FLIT_W].
- req_ready  output  NUM_IN  combinational; flit of input i accepted this cycle.
- credit_in  input  1  one credit returned by downstream this cycle.
- out_valid  output  1  registered; out_flit/out_head/out_tail are valid this cycle.
- out_flit  output  FLIT_W  registered forwarded payload.
- out_head, out_tail  output  1 each  registered flit markers.
- olck  output  1  output is locked to an input.
- olck_owner  output  IDX_W  index of the locked input; holds its last value when unlocked.
- credit_cnt  output  CNT_W  current credits.
- credit_err  output  1  sticky; set when credit_in arrives while credit_cnt == CREDITS.

## Operation
- States: IDLE (olck=0) and LOCKED (olck=1).
- **IDLE:** candidates are inputs with req_valid & req_head.
  - If any candidate exists and credit_cnt > 0, pick the first candidate searching from rr_ptr upward, wrapping modulo NUM_IN.
  - Then set olck_owner to that input and go to LOCKED.
  - No flit is accepted in the grant cycle.
  - req_ready is 0 in IDLE.
  - Valid non-head flits are ignored in IDLE.
- **LOCKED:** req_ready[owner] = req_valid[owner] & (credit_cnt > 0); all other req_ready bits are 0.
  - On acceptance: capture the owner's flit, head and tail into the output register, and decrement credit.
  - If the accepted flit has tail=1: go to IDLE and set rr_ptr = (owner+1) mod NUM_IN.
  - If the owner drops req_valid mid-packet, stay LOCKED indefinitely; there is no timeout.
- **Credits:**
  - credit_in alone: +1.
  - Acceptance alone: −1.
  - Both in the same cycle: unchanged.
  - credit_in while credit_cnt == CREDITS: counter stays at CREDITS and credit_err is set. credit_err clears only on reset.
- **Reset values:**
  - Outputs: out_valid=0, out_flit=0, out_head=0, out_tail=0, olck=0, olck_owner=0, credit_cnt=CREDITS, credit_err=0.
  - Internal: rr_ptr=0, state IDLE.
  - Reset asserted mid-packet aborts the lock immediately; the downstream partial packet is not completed.

## Timing
- Grant: head visible in cycle k (IDLE) → olck=1 from cycle k+1.
- Acceptance: req_ready high in cycle k+1 at the earliest, when credits are available.
- Forwarding: acceptance in cycle j → out_valid=1 in cycle j+1 for exactly one cycle. Back-to-back acceptance gives a continuous out_valid stream.
- Minimum head-to-output latency is 2 cycles.
- Gap after a tail: tail accepted in cycle j → IDLE in j+1 → next grant in j+1 → next head accepted no earlier than j+2.
- credit_cnt updates in the cycle after credit_in / acceptance. With credit_cnt=1, one acceptance in cycle j blocks req_ready in j+1 unless credit_in was also high in cycle j.

## Test plan
- **Single-flit packet:** reset, then input 2 presents head=tail=1 with flit 0xA5A5_0001. Required: olck=1 with owner=2 in the next cycle, req_ready[2]=1 that cycle, out_valid with 0xA5A5_0001 one cycle later, credit_cnt 4→3, back to IDLE, rr_ptr=3.
- **Round-robin fairness:** inputs 0, 1 and 3 continuously send 1-flit packets, with credit_in returned every cycle. Required: grant order 0,1,3,0,1,3 and no input granted twice before the others.
- **Credit exhaustion:** CREDITS=4, 6-flit packet from input 1, no credit_in. Required: exactly 4 flits forwarded, then req_ready[1]=0 while olck stays 1. A single credit_in pulse releases exactly one more flit.
- **Lock hold:** while input 0 is mid-packet, input 1 presents a head flit. Required: req_ready[1]=0 until input 0's tail has been accepted; input 1 is granted the following cycle.
- **Credit overflow and simultaneous events:** credit_in at credit_cnt=4 → credit_err=1 sticky, count stays 4. Acceptance together with credit_in at count 2 → count stays 2.
- **Reset mid-packet:** reset low while locked with count 1. Required: olck=0, out_valid=0, credit_cnt=4, credit_err=0 immediately, without waiting for a clock edge.
